// File: rtl/test_end_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : test_end_ctrl
// Purpose  : End-of-test controller. Holds the DUT in reset, round-robin
//            arbitrates pass/fail reports, enforces a cycle timeout, gates
//            waveform dumping and drains before flagging done.
//            Optional heartbeat watchdog: define TEST_END_CTRL_WATCHDOG_EN.
// Revision : 1.0
// ============================================================================

module test_end_ctrl #(
    parameter int NREQ         = 4,
    parameter int CODE_W       = 8,
    parameter int CYC_W        = 64,
    parameter int RESET_CYCLES = 16,
    parameter int DRAIN_CYCLES = 8,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CYC_W-1:0]       max_cycles,
    input  logic [CYC_W-1:0]       dump_start,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CODE_W-1:0] req_code,
`ifdef TEST_END_CTRL_WATCHDOG_EN
    input  logic                   heartbeat,
`endif
    output logic [NREQ-1:0]        req_ready,
    output logic                   dut_reset,
    output logic                   dump_en,
    output logic [CYC_W-1:0]       cycle_count,
    output logic                   done,
    output logic                   success,
    output logic [CODE_W-1:0]      fail_code,
    output logic                   timeout
);

    localparam int c_ptr_w   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_hold_w  = $clog2(RESET_CYCLES + 1);
    localparam int c_drain_w = $clog2(DRAIN_CYCLES + 1);

    localparam logic [NREQ-1:0]   c_all_pass  = '1;
    localparam logic [CODE_W-1:0] c_wdog_code = CODE_W'(8'hFE);

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [c_hold_w-1:0]    hold_cnt_q, hold_cnt_d;
    logic [c_drain_w-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CYC_W-1:0]       cycle_count_q, cycle_count_d;
    logic                   dump_en_q, dump_en_d;
    logic                   dut_reset_q, dut_reset_d;
    logic [c_ptr_w-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]        pass_mask_q, pass_mask_d;
    logic                   v_fail_q, v_fail_d;
    logic [CODE_W-1:0]      v_code_q, v_code_d;
    logic                   v_to_q, v_to_d;
    logic                   done_q, done_d;
    logic                   success_q, success_d;
    logic [CODE_W-1:0]      fail_code_q, fail_code_d;
    logic                   timeout_q, timeout_d;

    logic                   w_grant_found;
    logic [c_ptr_w-1:0]     w_grant_idx;
    logic [NREQ-1:0]        w_grant;
    logic [CODE_W-1:0]      w_code_sel;
    logic                   w_hs;
    logic                   w_timeout;
    logic                   w_wdog_fire;
    logic                   w_run_end;

    // Rotating priority search: first valid requester at or after ptr_q.
    always_comb begin
        logic [c_ptr_w:0] idx;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        idx           = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (c_ptr_w + 1)'(k);
            if (idx >= (c_ptr_w + 1)'(NREQ)) begin
                idx = idx - (c_ptr_w + 1)'(NREQ);
            end
            if (!w_grant_found && req_valid[idx[c_ptr_w-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = idx[c_ptr_w-1:0];
            end
        end
    end

    always_comb begin
        w_grant    = '0;
        w_code_sel = '0;
        if (state_q == ST_RUN && w_grant_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == c_ptr_w'(i)) begin
                w_code_sel = req_code[i*CODE_W +: CODE_W];
            end
        end
    end

    assign w_hs      = |w_grant;
    assign w_timeout = (max_cycles != '0) && (cycle_count_q > max_cycles);

`ifdef TEST_END_CTRL_WATCHDOG_EN
    localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);

    logic [c_wdog_w-1:0] wdog_cnt_q, wdog_cnt_d;

    always_comb begin
        wdog_cnt_d = '0;
        if (state_q == ST_RUN && !heartbeat) begin
            wdog_cnt_d = (wdog_cnt_q == c_wdog_w'(WDOG_CYCLES)) ? wdog_cnt_q
                                                                  : wdog_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end

    assign w_wdog_fire = (state_q == ST_RUN) && (wdog_cnt_q == c_wdog_w'(WDOG_CYCLES));
`else
    logic [31:0] unused_wdog_cycles;
    assign unused_wdog_cycles = 32'(WDOG_CYCLES);
    assign w_wdog_fire        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q;
        dump_en_d     = dump_en_q;
        ptr_d         = ptr_q;
        pass_mask_d   = pass_mask_q;
        v_fail_d      = v_fail_q;
        v_code_d      = v_code_q;
        v_to_d        = v_to_q;
        done_d        = done_q;
        success_d     = success_q;
        fail_code_d   = fail_code_q;
        timeout_d     = timeout_q;
        w_run_end     = 1'b0;

        if (state_q != ST_DONE && cycle_count_q != '1) begin
            cycle_count_d = cycle_count_q + CYC_W'(1);
        end

        case (state_q)
            ST_RST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == c_hold_w'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (w_hs) begin
                    ptr_d = (w_grant_idx == c_ptr_w'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
                    if (w_code_sel != '0) begin
                        w_run_end = 1'b1;
                        v_fail_d  = 1'b1;
                        v_code_d  = w_code_sel;
                        v_to_d    = 1'b0;
                    end else begin
                        pass_mask_d = pass_mask_q | w_grant;
                        if ((pass_mask_q | w_grant) == c_all_pass) begin
                            w_run_end = 1'b1;
                            v_fail_d  = 1'b0;
                            v_code_d  = '0;
                            v_to_d    = 1'b0;
                        end
                    end
                end
                // A terminating handshake outranks the watchdog, which outranks timeout.
                if (!w_run_end && w_wdog_fire) begin
                    w_run_end = 1'b1;
                    v_fail_d  = 1'b1;
                    v_code_d  = c_wdog_code;
                    v_to_d    = 1'b0;
                end else if (!w_run_end && w_timeout) begin
                    w_run_end = 1'b1;
                    v_fail_d  = 1'b1;
                    v_code_d  = '1;
                    v_to_d    = 1'b1;
                end
                if (w_run_end) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end

            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == c_drain_w'(DRAIN_CYCLES - 1)) begin
                    state_d     = ST_DONE;
                    done_d      = 1'b1;
                    success_d   = !v_fail_q;
                    fail_code_d = v_code_q;
                    timeout_d   = v_to_q;
                end
            end

            default: begin
            end
        endcase

        dut_reset_d = (state_d == ST_RST_HOLD);

        if (state_d == ST_DONE) begin
            dump_en_d = 1'b0;
        end else if (cycle_count_q == dump_start) begin
            dump_en_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RST_HOLD;
            hold_cnt_q    <= '0;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
            dump_en_q     <= 1'b0;
            dut_reset_q   <= 1'b1;
            ptr_q         <= '0;
            pass_mask_q   <= '0;
            v_fail_q      <= 1'b0;
            v_code_q      <= '0;
            v_to_q        <= 1'b0;
            done_q        <= 1'b0;
            success_q     <= 1'b0;
            fail_code_q   <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
            dump_en_q     <= dump_en_d;
            dut_reset_q   <= dut_reset_d;
            ptr_q         <= ptr_d;
            pass_mask_q   <= pass_mask_d;
            v_fail_q      <= v_fail_d;
            v_code_q      <= v_code_d;
            v_to_q        <= v_to_d;
            done_q        <= done_d;
            success_q     <= success_d;
            fail_code_q   <= fail_code_d;
            timeout_q     <= timeout_d;
        end
    end

    assign req_ready   = w_grant;
    assign dut_reset   = dut_reset_q;
    assign dump_en     = dump_en_q;
    assign cycle_count = cycle_count_q;
    assign done        = done_q;
    assign success     = success_q;
    assign fail_code   = fail_code_q;
    assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_test_end_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_end_ctrl
// Purpose  : Self-checking bench for test_end_ctrl (default parameters).
// Revision : 1.0
// ============================================================================

module tb_test_end_ctrl;

    localparam int NREQ   = 4;
    localparam int CODE_W = 8;
    localparam int CYC_W  = 64;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [CYC_W-1:0]       max_cycles = '0;
    logic [CYC_W-1:0]       dump_start = '0;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*CODE_W-1:0] req_code = '0;
    logic [NREQ-1:0]        req_ready;
    logic                   dut_reset;
    logic                   dump_en;
    logic [CYC_W-1:0]       cycle_count;
    logic                   done;
    logic                   success;
    logic [CODE_W-1:0]      fail_code;
    logic                   timeout;
`ifdef TEST_END_CTRL_WATCHDOG_EN
    logic                   heartbeat = 1'b1;
`endif

    test_end_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .max_cycles  (max_cycles),
        .dump_start  (dump_start),
        .req_valid   (req_valid),
        .req_code    (req_code),
`ifdef TEST_END_CTRL_WATCHDOG_EN
        .heartbeat   (heartbeat),
`endif
        .req_ready   (req_ready),
        .dut_reset   (dut_reset),
        .dump_en     (dump_en),
        .cycle_count (cycle_count),
        .done        (done),
        .success     (success),
        .fail_code   (fail_code),
        .timeout     (timeout)
    );

    always #5 clock = ~clock;

    // Bench-side cycle model: posedges since reset release.
    logic [63:0] tb_cyc;
    always @(posedge clock or posedge reset) begin
        if (reset) tb_cyc <= '0;
        else       tb_cyc <= tb_cyc + 64'd1;
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] code;
        logic [3:0]  exp_ready;
        logic        term;
        logic        exp_succ;
        logic [7:0]  exp_code;
    } vec_t;

    typedef struct {
        logic        succ;
        logic [7:0]  code;
        logic        to;
        logic [63:0] cc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] c, input logic [3:0] r,
                                input logic t, input logic s, input logic [7:0] fc);
        vec_t x;
        x.valid = v; x.code = c; x.exp_ready = r; x.term = t; x.exp_succ = s; x.exp_code = fc;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] mc, input logic [63:0] ds);
        tick();
        reset      = 1'b1;
        req_valid  = '0;
        req_code   = '0;
        max_cycles = mc;
        dump_start = ds;
        exp_q.delete();
        @(negedge clock);
        chk("rst_dut_reset", 64'(dut_reset), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dump_en", 64'(dump_en), 64'd0);
        chk("rst_cycle_count", cycle_count, 64'd0);
        chk("rst_success", 64'(success), 64'd0);
        chk("rst_fail_code", 64'(fail_code), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        tick();
        reset = 1'b0;
    endtask

    // Hold phase; requests offered here must never be granted.
    task automatic hold_phase(input logic [63:0] ds);
        req_valid = 4'hF;
        req_code  = 32'h55555555;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            chk("hold_dut_reset", 64'(dut_reset), 64'd1);
            chk("hold_cycle_count", cycle_count, tb_cyc);
            chk("hold_dump_en", 64'(dump_en), 64'(tb_cyc > ds));
            chk("hold_ready", 64'(req_ready), 64'd0);
            tick();
        end
        req_valid = '0;
        req_code  = '0;
    endtask

    task automatic apply_vec(input vec_t v);
        exp_t e;
        req_valid = v.valid;
        req_code  = v.code;
        @(negedge clock);
        chk("ready", 64'(req_ready), 64'(v.exp_ready));
        chk("run_dut_reset", 64'(dut_reset), 64'd0);
        chk("run_cycle_count", cycle_count, tb_cyc);
        if (v.term) begin
            e.succ = v.exp_succ; e.code = v.exp_code; e.to = 1'b0; e.cc = tb_cyc + 64'd9;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic wait_done();
        exp_t e;
        bit   seen;
        seen      = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL done_wait: got done=0 after 64 cycles, expected done=1");
        end else if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard: got done=1, expected no verdict yet");
        end else begin
            e = exp_q.pop_front();
            chk("done_success", 64'(success), 64'(e.succ));
            chk("done_fail_code", 64'(fail_code), 64'(e.code));
            chk("done_timeout", 64'(timeout), 64'(e.to));
            chk("done_cycle_count", cycle_count, e.cc);
            chk("done_dump_en", 64'(dump_en), 64'd0);
            repeat (3) tick();
            @(negedge clock);
            chk("done_sticky", 64'(done), 64'd1);
            chk("done_frozen_count", cycle_count, e.cc);
            chk("done_no_ready", 64'(req_ready), 64'd0);
        end
    endtask

    initial begin
        exp_t e;
        // Pass-all sequence exercising rotation, repeat pass, and drain.
        vecs.push_back(mk(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0010, 32'h0, 4'b0010, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0011, 32'h0, 4'b0001, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0010, 32'h0, 4'b0010, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(4'b1100, 32'h0, 4'b0100, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(4'b1001, 32'h0, 4'b1000, 1'b1, 1'b1, 8'h00));
        vecs.push_back(mk(4'b1111, 32'h0, 4'b0000, 1'b0, 1'b0, 8'h00));
        // Fail report from req3 after req1 is served first.
        vecs.push_back(mk(4'b1010, 32'h2A000000, 4'b0010, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(4'b1010, 32'h2A000000, 4'b1000, 1'b1, 1'b0, 8'h2A));

        // Reset hold, dump from cycle 1, all-pass verdict
        do_reset(64'd0, 64'd0);
        hold_phase(64'd0);
        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);
        wait_done();

        // Round-robin fail verdict, dump window opening at cycle 21
        do_reset(64'd0, 64'd20);
        hold_phase(64'd20);
        for (int i = 8; i < 10; i++) apply_vec(vecs[i]);
        req_valid = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("dump_window", 64'(dump_en), 64'(tb_cyc > 64'd20));
            tick();
        end
        wait_done();

        // Pure timeout at cycle_count 101
        do_reset(64'd100, 64'd0);
        hold_phase(64'd0);
        repeat (85) tick();
        @(negedge clock);
        chk("to_cycle_count", cycle_count, 64'd101);
        chk("to_still_running", 64'(done), 64'd0);
        e.succ = 1'b0; e.code = 8'hFF; e.to = 1'b1; e.cc = 64'd110;
        exp_q.push_back(e);
        tick();
        wait_done();

        // Mask-completing handshake in the timeout cycle wins
        do_reset(64'd100, 64'd0);
        hold_phase(64'd0);
        apply_vec(mk(4'b0001, 32'h0, 4'b0001, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b0010, 32'h0, 4'b0010, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b0100, 32'h0, 4'b0100, 1'b0, 1'b0, 8'h00));
        req_valid = '0;
        repeat (81) tick();
        apply_vec(mk(4'b0001, 32'h0, 4'b0001, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b1000, 32'h0, 4'b1000, 1'b1, 1'b1, 8'h00));
        wait_done();

        // Async reset mid-drain clears everything, including the pass mask
        do_reset(64'd0, 64'd0);
        hold_phase(64'd0);
        apply_vec(mk(4'b0001, 32'h0, 4'b0001, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b0010, 32'h0, 4'b0010, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b0100, 32'h0, 4'b0100, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b1000, 32'h11000000, 4'b1000, 1'b1, 1'b0, 8'h11));
        req_valid = 4'hF;
        repeat (2) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_dut_reset", 64'(dut_reset), 64'd1);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_dump_en", 64'(dump_en), 64'd0);
        chk("mid_rst_cycle_count", cycle_count, 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        hold_phase(64'd0);
        apply_vec(mk(4'b1000, 32'h0, 4'b1000, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b0001, 32'h0, 4'b0001, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b0110, 32'h0, 4'b0010, 1'b0, 1'b0, 8'h00));
        apply_vec(mk(4'b0100, 32'h0, 4'b0100, 1'b1, 1'b1, 8'h00));
        wait_done();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion by t=%0t, expected completion", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
